// File: rtl/complex_issue_sched.sv
// Issue scheduler for the complex (div/mod) FU: collapsing wakeup queue, oldest-ready select,
// and a latency-matched completion pipe. Optional perf counters under CIQ_PERF_CNT_EN.
module complex_issue_sched #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned WAKE_N = 2,
  parameter int unsigned FU_LAT = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_disp_valid,
  output logic                       o_disp_ready,
  input  logic [3:0]                 i_disp_gen_op,
  input  logic [4:0]                 i_disp_spec_op,
  input  logic [ROB_W-1:0]           i_disp_rob_idx,
  input  logic [PREG_W-1:0]          i_disp_prj,
  input  logic [PREG_W-1:0]          i_disp_prk,
  input  logic                       i_disp_rj_rdy,
  input  logic                       i_disp_rk_rdy,
  input  logic [PREG_W-1:0]          i_disp_prd,
  input  logic [WAKE_N-1:0]          i_wake_valid,
  input  logic [WAKE_N*PREG_W-1:0]   i_wake_tag,
  input  logic                       i_flush,
  output logic                       o_iq_valid,
  input  logic                       i_fu_ready,
  output logic [3:0]                 o_iq_gen_op,
  output logic [4:0]                 o_iq_spec_op,
  output logic [ROB_W-1:0]           o_iq_rob_idx,
  output logic [PREG_W-1:0]          o_iq_prj,
  output logic [PREG_W-1:0]          o_iq_prk,
  output logic [PREG_W-1:0]          o_iq_prd,
`ifdef CIQ_PERF_CNT_EN
  output logic [31:0]                o_perf_issue_cnt,
  output logic [31:0]                o_perf_stall_cnt,
`endif
  output logic                       o_fu_wake_valid,
  output logic [PREG_W-1:0]          o_fu_wake_tag
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [3:0]        r_gen [DEPTH];
  logic [4:0]        r_spec[DEPTH];
  logic [ROB_W-1:0]  r_rob [DEPTH];
  logic [PREG_W-1:0] r_prj [DEPTH];
  logic [PREG_W-1:0] r_prk [DEPTH];
  logic [PREG_W-1:0] r_prd [DEPTH];
  logic [DEPTH-1:0]  r_rj_rdy, r_rk_rdy;
  logic [CW-1:0]     r_count;
  logic [FU_LAT-1:0] r_pipe_v;
  logic [PREG_W-1:0] r_pipe_prd[FU_LAT];

  logic [3:0]        w_gen [DEPTH];
  logic [4:0]        w_spec[DEPTH];
  logic [ROB_W-1:0]  w_rob [DEPTH];
  logic [PREG_W-1:0] w_prj [DEPTH];
  logic [PREG_W-1:0] w_prk [DEPTH];
  logic [PREG_W-1:0] w_prd [DEPTH];
  logic [DEPTH-1:0]  w_rj_rdy, w_rk_rdy, w_mj, w_mk;
  logic [CW-1:0]     w_count, w_wr_idx;
  logic [IW-1:0]     w_sel;
  logic              w_found, w_issue, w_accept, w_dmj, w_dmk;

  function automatic logic tag_hit(input logic [WAKE_N-1:0]        wv,
                                   input logic [WAKE_N*PREG_W-1:0] wt,
                                   input logic                     fv,
                                   input logic [PREG_W-1:0]        ft,
                                   input logic [PREG_W-1:0]        tag);
    logic hit;
    hit = fv && (ft == tag);
    for (int p = 0; p < WAKE_N; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign o_fu_wake_valid = r_pipe_v[FU_LAT-1];
  assign o_fu_wake_tag   = r_pipe_prd[FU_LAT-1];
  assign o_disp_ready    = (r_count < CW'(DEPTH)) && !i_flush;
  assign w_accept        = i_disp_valid && o_disp_ready;

  // Readiness is taken from registered flags only; wakeups take effect next cycle.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((CW'(k) < r_count) && r_rj_rdy[k] && r_rk_rdy[k]) begin
        w_found = 1'b1;
        w_sel   = IW'(k);
      end
    end
  end

  assign o_iq_valid   = w_found && !i_flush;
  assign w_issue      = o_iq_valid && i_fu_ready;
  assign o_iq_gen_op  = o_iq_valid ? r_gen[w_sel]  : '0;
  assign o_iq_spec_op = o_iq_valid ? r_spec[w_sel] : '0;
  assign o_iq_rob_idx = o_iq_valid ? r_rob[w_sel]  : '0;
  assign o_iq_prj     = o_iq_valid ? r_prj[w_sel]  : '0;
  assign o_iq_prk     = o_iq_valid ? r_prk[w_sel]  : '0;
  assign o_iq_prd     = o_iq_valid ? r_prd[w_sel]  : '0;

  always_comb begin
    w_dmj = tag_hit(i_wake_valid, i_wake_tag, o_fu_wake_valid, o_fu_wake_tag, i_disp_prj);
    w_dmk = tag_hit(i_wake_valid, i_wake_tag, o_fu_wake_valid, o_fu_wake_tag, i_disp_prk);
    w_mj  = '0;
    w_mk  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_mj[k] = tag_hit(i_wake_valid, i_wake_tag, o_fu_wake_valid, o_fu_wake_tag, r_prj[k]);
      w_mk[k] = tag_hit(i_wake_valid, i_wake_tag, o_fu_wake_valid, o_fu_wake_tag, r_prk[k]);
    end
  end

  always_comb begin
    w_wr_idx = r_count - CW'(w_issue);
    w_count  = i_flush ? '0 : (r_count + CW'(w_accept) - CW'(w_issue));
    for (int k = 0; k < DEPTH; k++) begin
      w_gen[k]    = r_gen[k];
      w_spec[k]   = r_spec[k];
      w_rob[k]    = r_rob[k];
      w_prj[k]    = r_prj[k];
      w_prk[k]    = r_prk[k];
      w_prd[k]    = r_prd[k];
      w_rj_rdy[k] = r_rj_rdy[k] | w_mj[k];
      w_rk_rdy[k] = r_rk_rdy[k] | w_mk[k];
    end
    // Collapse: slots at or above the issued one take their younger neighbour.
    if (w_issue) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (IW'(k) >= w_sel) begin
          w_gen[k]    = r_gen[k+1];
          w_spec[k]   = r_spec[k+1];
          w_rob[k]    = r_rob[k+1];
          w_prj[k]    = r_prj[k+1];
          w_prk[k]    = r_prk[k+1];
          w_prd[k]    = r_prd[k+1];
          w_rj_rdy[k] = r_rj_rdy[k+1] | w_mj[k+1];
          w_rk_rdy[k] = r_rk_rdy[k+1] | w_mk[k+1];
        end
      end
    end
    if (w_accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) == w_wr_idx) begin
          w_gen[k]    = i_disp_gen_op;
          w_spec[k]   = i_disp_spec_op;
          w_rob[k]    = i_disp_rob_idx;
          w_prj[k]    = i_disp_prj;
          w_prk[k]    = i_disp_prk;
          w_prd[k]    = i_disp_prd;
          w_rj_rdy[k] = i_disp_rj_rdy | w_dmj;
          w_rk_rdy[k] = i_disp_rk_rdy | w_dmk;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_rj_rdy <= '0;
      r_rk_rdy <= '0;
      r_pipe_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_gen[k]  <= '0;
        r_spec[k] <= '0;
        r_rob[k]  <= '0;
        r_prj[k]  <= '0;
        r_prk[k]  <= '0;
        r_prd[k]  <= '0;
      end
      for (int s = 0; s < FU_LAT; s++) r_pipe_prd[s] <= '0;
    end else begin
      r_count  <= w_count;
      r_rj_rdy <= w_rj_rdy;
      r_rk_rdy <= w_rk_rdy;
      for (int k = 0; k < DEPTH; k++) begin
        r_gen[k]  <= w_gen[k];
        r_spec[k] <= w_spec[k];
        r_rob[k]  <= w_rob[k];
        r_prj[k]  <= w_prj[k];
        r_prk[k]  <= w_prk[k];
        r_prd[k]  <= w_prd[k];
      end
      r_pipe_v[0]   <= w_issue;
      r_pipe_prd[0] <= o_iq_prd;
      for (int s = 1; s < FU_LAT; s++) begin
        r_pipe_v[s]   <= r_pipe_v[s-1] && !i_flush;
        r_pipe_prd[s] <= r_pipe_prd[s-1];
      end
    end
  end

`ifdef CIQ_PERF_CNT_EN
  logic [31:0] r_perf_issue, r_perf_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue && (r_perf_issue != 32'hFFFF_FFFF)) r_perf_issue <= r_perf_issue + 32'd1;
      if ((r_count != '0) && !o_iq_valid && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign o_perf_issue_cnt = r_perf_issue;
  assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule
